// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler that shares one multiply-accumulate datapath between
// NUM_REQ AXI4-Stream packet sources and emits one tagged sum per packet.
module mac_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ACC_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     s_axis_tvalid,
  output logic [NUM_REQ-1:0]     s_axis_tready,
  input  logic [NUM_REQ*16-1:0]  s_axis_tdata,
  input  logic [NUM_REQ-1:0]     s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [ACC_W-1:0]       m_axis_tdata,
  output logic [ID_W-1:0]        m_axis_tid,
  output logic [8:0]             m_axis_tuser,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t          state;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] last_grant;
  logic [ACC_W-1:0] acc;
  logic [7:0]      count;
  logic            ovf;

  logic [15:0]     beat;
  logic [15:0]     prod;
  logic [ACC_W:0]  sum;
  logic [7:0]      count_nxt;
  logic            ovf_nxt;
  logic            accept;
  logic            last_beat;
  logic            sel;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hff) ? c : c + 8'd1;
  endfunction

  // Walk downward so the nearest index after 'last' is the final assignment.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (vld[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    s_axis_tready = '0;
    beat          = '0;
    accept        = 1'b0;
    last_beat     = 1'b0;
    sel           = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel = (state == ACCUM) && (grant == ID_W'(i));
      s_axis_tready[i] = sel;
      if (sel) begin
        beat      = s_axis_tdata[16*i +: 16];
        accept    = s_axis_tvalid[i];
        last_beat = s_axis_tlast[i];
      end
    end
    prod      = 16'(beat[15:8]) * 16'(beat[7:0]);
    sum       = {1'b0, acc} + (ACC_W+1)'(prod);
    count_nxt = sat_inc(count);
    ovf_nxt   = ovf | sum[ACC_W];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= ID_W'(NUM_REQ - 1);
      acc           <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      m_axis_tuser  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_axis_tvalid) begin
            grant <= rr_pick(s_axis_tvalid, last_grant);
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= sum[ACC_W-1:0];
            count <= count_nxt;
            ovf   <= ovf_nxt;
            if (last_beat) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= sum[ACC_W-1:0];
              m_axis_tid    <= grant;
              m_axis_tuser  <= {count_nxt, ovf_nxt};
              last_grant    <= grant;
              state         <= OUT;
            end
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed-vector bench for mac_rr_scheduler: arbitration order, sums,
// overflow, gaps, output backpressure and mid-packet reset.
module tb_mac_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  s_tvalid = '0;
  logic [3:0]  s_tready;
  logic [63:0] s_tdata = '0;
  logic [3:0]  s_tlast = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [15:0] m_tdata;
  logic [1:0]  m_tid;
  logic [8:0]  m_tuser;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int n_results = 0;
  int n_acc [4] = '{0, 0, 0, 0};
  int rdy3_early = 0;
  int guard = 0;
  int base_acc;
  int base_rdy3;
  int k;

  logic [1:0]  q_tid  [$];
  logic [15:0] q_data [$];
  logic [8:0]  q_user [$];
  logic [15:0] pa [8];
  logic [15:0] pb [8];
  logic [15:0] pc [8];

  mac_rr_scheduler #(.NUM_REQ(4), .ID_W(2), .ACC_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tid    (m_tid),
    .m_axis_tuser  (m_tuser),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        if (s_tvalid[i] && s_tready[i]) n_acc[i]++;
      if (m_tvalid && m_tready) begin
        q_tid.push_back(m_tid);
        q_data.push_back(m_tdata);
        q_user.push_back(m_tuser);
        n_results++;
      end
    end
    if (s_tready[3] && n_results < guard) rdy3_early++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_pkt(input int r, input int n, input logic [15:0] bt [8], input bit gap);
    int  cyc;
    bit  done;
    for (int b = 0; b < n; b++) begin
      s_tvalid[r] = 1'b1;
      s_tdata[16*r +: 16] = bt[b];
      s_tlast[r] = (b == n - 1);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 300) begin
        @(negedge clk);
        if (s_tready[r] && reset) done = 1'b1;
        cyc++;
      end
      if (!done) check($sformatf("beat_accept_r%0d", r), 32'(done), 32'd1);
      @(posedge clk); #1;
      s_tvalid[r] = 1'b0;
      s_tlast[r]  = 1'b0;
      if (gap && b < n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic expect_result(input string tag, input int tid, input int data,
                               input int cnt, input bit ovf);
    int cyc = 0;
    while (q_tid.size() == 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_avail"}, 32'(q_tid.size() != 0), 32'd1);
    if (q_tid.size() != 0) begin
      check({tag, "_tid"},  32'(q_tid.pop_front()),  32'(tid));
      check({tag, "_data"}, 32'(q_data.pop_front()), 32'(data));
      check({tag, "_user"}, 32'(q_user.pop_front()), 32'((cnt << 1) | int'(ovf)));
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata",  32'(m_tdata),  32'd0);
    check("rst_m_tid",    32'(m_tid),    32'd0);
    check("rst_m_tuser",  32'(m_tuser),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);

    // contention: req1 twice and req3 once, both valid from reset release
    pa = '{16'h0102, 16'h0304, 0, 0, 0, 0, 0, 0};
    pb = '{16'h0202, 16'h0202, 0, 0, 0, 0, 0, 0};
    pc = '{16'h0505, 16'h0101, 0, 0, 0, 0, 0, 0};
    guard = 1;
    base_rdy3 = rdy3_early;
    reset = 1'b1;
    fork
      begin
        send_pkt(1, 2, pa, 1'b0);
        send_pkt(1, 2, pb, 1'b0);
      end
      send_pkt(3, 2, pc, 1'b0);
    join
    expect_result("cont0", 1, 14, 2, 1'b0);
    expect_result("cont1", 3, 26, 2, 1'b0);
    expect_result("cont2", 1, 8, 2, 1'b0);
    check("cont_rdy3_during_req1", 32'(rdy3_early - base_rdy3), 32'd0);
    guard = 0;

    // single packet on req0
    repeat (2) @(posedge clk);
    #1;
    base_acc = n_acc[0];
    pa = '{16'h0203, 16'h0405, 16'h0101, 0, 0, 0, 0, 0};
    send_pkt(0, 3, pa, 1'b0);
    expect_result("single", 0, 27, 3, 1'b0);
    check("single_beats", 32'(n_acc[0] - base_acc), 32'd3);

    // backpressure on the result
    repeat (2) @(posedge clk);
    #1;
    m_tready = 1'b0;
    pa = '{16'h0304, 16'h0506, 0, 0, 0, 0, 0, 0};
    send_pkt(2, 2, pa, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_tvalid_%0d", c), 32'(m_tvalid), 32'd1);
      check($sformatf("bp_tdata_%0d", c),  32'(m_tdata),  32'd42);
      check($sformatf("bp_tid_%0d", c),    32'(m_tid),    32'd2);
      check($sformatf("bp_stready_%0d", c), 32'(s_tready), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_tvalid_held_5", 32'(m_tvalid), 32'd1);
    m_tready = 1'b1;
    @(posedge clk); #1;
    check("bp_tvalid_cleared", 32'(m_tvalid), 32'd0);
    check("bp_busy_cleared",   32'(busy),     32'd0);
    expect_result("bp", 2, 42, 2, 1'b0);

    // overflow wrap on req2
    pa = '{16'hffff, 16'hffff, 0, 0, 0, 0, 0, 0};
    send_pkt(2, 2, pa, 1'b0);
    expect_result("ovf", 2, 64514, 2, 1'b1);

    // gaps on req0 while req3 arrives mid-packet
    repeat (2) @(posedge clk);
    #1;
    pa = '{16'h0101, 16'h0101, 16'h0101, 16'h0101, 16'h0101, 0, 0, 0};
    pb = '{16'h0202, 0, 0, 0, 0, 0, 0, 0};
    guard = n_results + 1;
    base_rdy3 = rdy3_early;
    fork
      send_pkt(0, 5, pa, 1'b1);
      begin
        for (int c = 0; c < 100 && !s_tready[0]; c++) @(negedge clk);
        @(posedge clk); #1;
        send_pkt(3, 1, pb, 1'b0);
      end
    join
    expect_result("gap", 0, 5, 5, 1'b0);
    expect_result("gap_next", 3, 4, 1, 1'b0);
    check("gap_lock_rdy3", 32'(rdy3_early - base_rdy3), 32'd0);
    guard = 0;

    // reset after two of four beats
    repeat (2) @(posedge clk);
    #1;
    s_tvalid[0] = 1'b1;
    s_tdata[15:0] = 16'h0101;
    s_tlast[0] = 1'b0;
    k = 0;
    for (int c = 0; c < 100 && k < 2; c++) begin
      @(negedge clk);
      if (s_tready[0]) k++;
    end
    check("rstmid_two_beats", 32'(k), 32'd2);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rstmid_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rstmid_m_tdata",  32'(m_tdata),  32'd0);
    check("rstmid_m_tid",    32'(m_tid),    32'd0);
    check("rstmid_m_tuser",  32'(m_tuser),  32'd0);
    check("rstmid_busy",     32'(busy),     32'd0);
    check("rstmid_s_tready", 32'(s_tready), 32'd0);
    reset = 1'b1;
    pa = '{16'h0101, 16'h0101, 0, 0, 0, 0, 0, 0};
    send_pkt(0, 2, pa, 1'b0);
    expect_result("rstmid", 0, 2, 2, 1'b0);
    check("rstmid_no_stale", 32'(q_tid.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_rr_scheduler.md
Name: mac_rr_scheduler

Overview:
- Shares one multiply-accumulate datapath between NUM_REQ AXI4-Stream requesters (neuron input streams).
- Each requester sends a packet of packed {weight, data} beats terminated by tlast. The scheduler grants one packet at a time, round-robin, and accumulates weight*data over the packet.
- Emits one result per packet on an AXI4-Stream master, tagged with the requester ID, beat count and overflow flag.
- Sits between the input-spike buffers and the neuron membrane/threshold logic.

Parameters:
- NUM_REQ, 4, number of requester streams (2..8).
- ID_W, 2, width of requester index; must equal clog2(NUM_REQ).
- ACC_W, 16, accumulator and result width (>=16).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- s_axis_tvalid  in  NUM_REQ  per-requester beat valid.
- s_axis_tready  out  NUM_REQ  per-requester beat ready.
- s_axis_tdata  in  NUM_REQ*16  requester i at [16i+15:16i]; packed {weight[15:8], data[7:0]}, both unsigned.
- s_axis_tlast  in  NUM_REQ  last beat of packet.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  ACC_W  accumulated packet sum.
- m_axis_tid  out  ID_W  requester index the result belongs to.
- m_axis_tuser  out  9  [0] overflow (sticky wrap within packet); [8:1] beat count, saturating at 255.
- busy  out  1  high in ACCUM or OUT state.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, acc=0, count=0, ovf=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0, m_axis_tuser=0, busy=0, s_axis_tready=0.
  - Reset mid-packet discards the partial packet and any pending result; the requester's remaining beats form a new packet afterwards.
- s_axis_tready is combinational from registered state: bit i = (state==ACCUM && grant==i). All other bits are 0. It never depends on s_axis_tvalid.
- IDLE:
  - If any tvalid is high, pick the first valid index searching last_grant+1, +2, ... modulo NUM_REQ.
  - Register it as grant; acc=0, count=0, ovf=0; go to ACCUM.
  - One cycle arbitration latency. No tready in IDLE.
  - With no valid requester, stay in IDLE.
- ACCUM:
  - A beat is accepted when tvalid[grant] && tready[grant].
  - On acceptance: prod = weight*data (16-bit unsigned, zero-extended to ACC_W+1).
  - sum = acc + prod, truncated to ACC_W (wraps modulo 2^ACC_W). ovf |= carry out. count = min(count+1, 255).
  - tvalid low cycles inside a packet are gaps: state held, no accumulation.
  - Other requesters' tvalid is ignored until the packet ends; grant is locked for the whole packet.
  - On an accepted beat with tlast:
    - m_axis_tdata = final sum (including this beat), m_axis_tid = grant, m_axis_tuser = {final count, final ovf}.
    - m_axis_tvalid=1 on the next cycle; last_grant=grant; go to OUT.
  - A single-beat packet (tlast on first beat) is legal.
- OUT:
  - Hold m_axis_tvalid, tdata, tid and tuser stable until m_axis_tready==1 at a clk edge.
  - Then clear m_axis_tvalid and go to IDLE.
  - All s_axis_tready are 0 while in OUT.
  - m_axis_tready high in the same cycle tvalid rises completes the transfer in that cycle.
- Timing:
  - Throughput: one beat per cycle in ACCUM.
  - Per-packet overhead: 1 IDLE cycle plus at least 1 OUT cycle.
  - Result latency: tlast accepted at edge N gives m_axis_tvalid high after edge N.
- Fairness: the next requester after last_grant wins, so a continuously valid requester cannot take two consecutive packets while another is waiting.
- busy = (state != IDLE).

Test Plan:
- Single packet: req0 beats {w,d} = (2,3), (4,5), (1,1 tlast), m_tready=1 → one result: tdata=27, tid=0, tuser count=3, ovf=0; tready[0] high for exactly 3 accepted beats.
- Contention: req1 and req3 valid from reset release, 2-beat packets each, req1 re-requests immediately → grant order 1, 3, 1; no tready to req3 while req1 is granted.
- Backpressure: m_tready=0 for 5 cycles after a result → tvalid/tdata/tid held for 5 cycles; all s_tready=0; the transfer completes on the 6th edge.
- Overflow: ACC_W=16, req2 beats (255,255), (255,255 tlast) → tdata=64514 (130050 mod 65536), ovf=1, count=2.
- Gaps: req0 5-beat packet of (1,1) with tvalid low every other cycle → tdata=5, count=5; arbitration stays locked on req0.
- Reset mid-packet: reset low after 2 of 4 beats → all outputs 0 next cycle; after release, the remaining 2 beats (1,1)(1,1 tlast) produce tdata=2, count=2, tid=0.
